// File: rtl/interconn_pkg.sv
// Shared definitions for the buffered source-routed crossbar.
// Combinational only; no backpressure of its own.
package interconn_pkg;

    function automatic int addr_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    // Queued entries are packed as {dest, word}.
    function automatic int entry_w(input int n, input int w);
        return addr_w(n) + w;
    endfunction

    localparam logic RST_VLD = 1'b0;
    localparam logic RST_OVF = 1'b0;
    localparam logic RST_RDY = 1'b1;

endpackage

// File: rtl/interconn_fifo.sv
// Per-source word queue with head-of-line read and registered occupancy count.
// Head is valid the cycle after the first push; push into a full FIFO and pop from an empty one are ignored.
module interconn_fifo
    import interconn_pkg::*;
#(
    parameter int W = 8,
    parameter int D = 4
)(
    input  logic                 clk,
    input  logic                 clr,
    input  logic                 push,
    input  logic                 pop,
    input  logic [W-1:0]         din,
    output logic [W-1:0]         head,
    output logic [$clog2(D):0]   count,
    output logic                 full,
    output logic                 empty
);
    localparam int PW = $clog2(D);

    logic [W-1:0]  mem_q [D];
    logic [PW-1:0] wr_q, wr_d;
    logic [PW-1:0] rd_q, rd_d;
    logic [PW:0]   cnt_q, cnt_d;
    logic          do_push, do_pop;

    assign full    = (cnt_q == (PW+1)'(D));
    assign empty   = (cnt_q == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;

    // D is a power of two, so plain increment wraps the pointers.
    always_comb begin
        wr_d  = wr_q;
        rd_d  = rd_q;
        cnt_d = cnt_q;
        if (do_push) wr_d = wr_q + 1'b1;
        if (do_pop)  rd_d = rd_q + 1'b1;
        case ({do_push, do_pop})
            2'b10:   cnt_d = cnt_q + 1'b1;
            2'b01:   cnt_d = cnt_q - 1'b1;
            default: cnt_d = cnt_q;
        endcase
    end

    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            wr_q  <= '0;
            rd_q  <= '0;
            cnt_q <= '0;
        end else begin
            wr_q  <= wr_d;
            rd_q  <= rd_d;
            cnt_q <= cnt_d;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_q] <= din;
    end

    assign head  = mem_q[rd_q];
    assign count = cnt_q;

endmodule

// File: rtl/interconn_rr.sv
// Buffered source-routed N x N crossbar: per-source FIFOs, per-destination round-robin into registered outputs.
// Latency 2 cycles from push to recv_en on an idle path; 1 word/cycle/destination throughput.
// A stalled output holds its word and grants nothing; send_rdy drops only on a full FIFO (no same-cycle credit).
module interconn_rr
    import interconn_pkg::*;
#(
    parameter int N = 8,
    parameter int W = 128,
    parameter int D = 4
)(
    input  logic                    clk,
    input  logic                    clr,
    input  logic [N-1:0]            send_en,
    input  logic [N*addr_w(N)-1:0]  send_dest,
    input  logic [N*W-1:0]          send_word,
    output logic [N-1:0]            send_rdy,
    output logic [N-1:0]            recv_en,
    output logic [N*W-1:0]          recv_word,
    output logic [N*addr_w(N)-1:0]  recv_src,
    input  logic [N-1:0]            recv_rdy,
    output logic [N-1:0]            ovf
);
    localparam int A  = addr_w(N);
    localparam int EW = entry_w(N, W);
    localparam int CW = $clog2(D) + 1;

    typedef struct packed {
        logic [A-1:0] dest;
        logic [W-1:0] word;
    } entry_t;

    entry_t               head [N];
    logic [N-1:0]         dest_ok, push, pop, full, empty;
    logic [N-1:0]         ovf_q, ovf_d;
    logic [N-1:0][N-1:0]  req;
    logic [N-1:0]         gnt [N];

    for (genvar i = 0; i < N; i++) begin : g_src
        entry_t        din;
        logic [CW-1:0] count;

        assign din.dest   = (N == 1) ? '0 : send_dest[i*A +: A];
        assign din.word   = send_word[i*W +: W];
        assign dest_ok[i] = (N == 1) || ({1'b0, send_dest[i*A +: A]} < (A+1)'(N));
        assign push[i]    = send_en[i] && !full[i] && dest_ok[i];
        assign send_rdy[i] = (count != CW'(D));

        interconn_fifo #(
            .W (EW),
            .D (D)
        ) u_fifo (
            .clk   (clk),
            .clr   (clr),
            .push  (push[i]),
            .pop   (pop[i]),
            .din   (din),
            .head  (head[i]),
            .count (count),
            .full  (full[i]),
            .empty (empty[i])
        );
    end

    // Rejected pushes (full FIFO or unroutable destination) are sticky until reset.
    assign ovf_d = ovf_q | (send_en & (full | ~dest_ok));

    always_ff @(posedge clk or posedge clr) begin
        if (clr) ovf_q <= {N{RST_OVF}};
        else     ovf_q <= ovf_d;
    end

    assign ovf = ovf_q;

    // Each head targets exactly one destination, so grants never collide across outputs.
    always_comb begin
        req = '0;
        for (int j = 0; j < N; j++) begin
            for (int i = 0; i < N; i++) begin
                req[j][i] = !empty[i] && ((N == 1) || (head[i].dest == A'(j)));
            end
        end
    end

    always_comb begin
        pop = '0;
        for (int j = 0; j < N; j++) pop = pop | gnt[j];
    end

    for (genvar j = 0; j < N; j++) begin : g_dst
        logic         en_q, en_d;
        logic [W-1:0] word_q, word_d;
        logic [A-1:0] src_q, src_d;
        logic [A-1:0] ptr_q, ptr_d;
        logic [A-1:0] win;
        logic         found;
        logic         load;
        logic [N-1:0] oh;

        always_comb begin
            win   = '0;
            found = 1'b0;
            for (int k = 0; k < N; k++) begin
                if (!found && req[j][(int'(ptr_q) + k) % N]) begin
                    found = 1'b1;
                    win   = A'((int'(ptr_q) + k) % N);
                end
            end

            load = (!en_q || recv_rdy[j]) && found;

            oh = '0;
            if (load) oh[win] = 1'b1;

            en_d   = en_q;
            word_d = word_q;
            src_d  = src_q;
            ptr_d  = ptr_q;
            if (load) begin
                en_d   = 1'b1;
                word_d = head[win].word;
                src_d  = win;
                ptr_d  = (int'(win) == N - 1) ? '0 : win + 1'b1;
            end else if (recv_rdy[j]) begin
                en_d   = 1'b0;
            end
        end

        always_ff @(posedge clk or posedge clr) begin
            if (clr) begin
                en_q   <= RST_VLD;
                word_q <= '0;
                src_q  <= '0;
                ptr_q  <= '0;
            end else begin
                en_q   <= en_d;
                word_q <= word_d;
                src_q  <= src_d;
                ptr_q  <= ptr_d;
            end
        end

        assign gnt[j]              = oh;
        assign recv_en[j]          = en_q;
        assign recv_word[j*W +: W] = word_q;
        assign recv_src[j*A +: A]  = src_q;
    end

endmodule
